z3_bus_master: RTL and testbench

Zorro III bus initiator. It accepts single-longword read/write requests from a local requester over a REQ/ACK handshake, then runs the full bus sequence: arbitration (BR_n/BG_n/BGACK_n), multiplexed address phase, FCS_n strobe, data phase with DS[3:0] and DOE, and termination on DTACK_n, BERR_n or timeout. It is the initiator counterpart to the card's memory/autoconfig responder logic. Pins are exposed as out/in/output-enable triples; the top level builds the tristates.

---
 rtl/z3_bus_master.sv | 188 ++++++++++++++++++
 tb/tb_z3_bus_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/z3_bus_master.sv
// Zorro III bus initiator: runs one longword read/write bus cycle per
// REQ/ACK handshake (arbitration, address phase, FCS_n, data phase, termination).
module z3_bus_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [2:0]  FC_VAL  = 3'b101
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        rw_i,
    input  logic [29:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        br_n_o,
    input  logic        bg_n_i,
    output logic        bgack_n_o,
    output logic [5:0]  a_out_o,
    output logic [31:0] ad_out_o,
    input  logic [31:0] ad_in_i,
    output logic        ad_oe_o,
    output logic        a_oe_o,
    output logic        read_o,
    output logic [2:0]  fc_o,
    output logic        fcs_n_o,
    output logic [3:0]  ds_o,
    output logic        doe_o,
    input  logic        dtack_n_i,
    input  logic        berr_n_i
);

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        ADDR = 3'd2,
        STRB = 3'd3,
        DATA = 3'd4,
        TERM = 3'd5
    } state_t;

    state_t             state_q;
    logic               bg_meta_q, bg_sync_q;
    logic               dtack_meta_q, dtack_sync_q;
    logic               berr_meta_q, berr_sync_q;
    logic               rw_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ack_q, err_q, br_n_q, bgack_n_q, ad_oe_q, a_oe_q;
    logic               read_q, fcs_n_q, doe_q;
    logic [31:0]        rdata_q, ad_out_q;
    logic [5:0]         a_out_q;
    logic [2:0]         fc_q;
    logic [3:0]         ds_q;
    logic               done_c;

    // Two-flop synchronisers for the asynchronous bus inputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bg_meta_q    <= 1'b1;
            bg_sync_q    <= 1'b1;
            dtack_meta_q <= 1'b1;
            dtack_sync_q <= 1'b1;
            berr_meta_q  <= 1'b1;
            berr_sync_q  <= 1'b1;
        end else begin
            bg_meta_q    <= bg_n_i;
            bg_sync_q    <= bg_meta_q;
            dtack_meta_q <= dtack_n_i;
            dtack_sync_q <= dtack_meta_q;
            berr_meta_q  <= berr_n_i;
            berr_sync_q  <= berr_meta_q;
        end
    end

    // Data phase ends on bus error, acknowledge, or the last timeout cycle
    assign done_c = !berr_sync_q || !dtack_sync_q || (cnt_q == CNT_LAST);

    // Bus sequencer with registered pin outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rw_q      <= 1'b0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            br_n_q    <= 1'b1;
            bgack_n_q <= 1'b1;
            a_out_q   <= 6'h0;
            ad_out_q  <= 32'h0;
            ad_oe_q   <= 1'b0;
            a_oe_q    <= 1'b0;
            read_q    <= 1'b0;
            fc_q      <= 3'b000;
            fcs_n_q   <= 1'b1;
            ds_q      <= 4'hF;
            doe_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        rw_q     <= rw_i;
                        be_q     <= be_i;
                        wdata_q  <= wdata_i;
                        a_out_q  <= addr_i[5:0];
                        ad_out_q <= {addr_i[29:6], 8'h00};
                        br_n_q   <= 1'b0;
                        state_q  <= ARB;
                    end
                end
                ARB: begin
                    // Wait indefinitely for the grant
                    if (!bg_sync_q) begin
                        bgack_n_q <= 1'b0;
                        br_n_q    <= 1'b1;
                        a_oe_q    <= 1'b1;
                        ad_oe_q   <= 1'b1;
                        read_q    <= rw_q;
                        fc_q      <= FC_VAL;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    fcs_n_q <= 1'b0;
                    state_q <= STRB;
                end
                STRB: begin
                    ds_q    <= ~be_q;
                    doe_q   <= 1'b1;
                    ad_oe_q <= ~rw_q;
                    if (!rw_q) begin
                        ad_out_q <= wdata_q;
                    end
                    cnt_q   <= '0;
                    state_q <= DATA;
                end
                DATA: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (done_c) begin
                        // BERR takes priority; DTACK high here means timeout
                        err_q <= !berr_sync_q || dtack_sync_q;
                        if (berr_sync_q && !dtack_sync_q && rw_q) begin
                            rdata_q <= ad_in_i;
                        end
                        ack_q     <= 1'b1;
                        fcs_n_q   <= 1'b1;
                        ds_q      <= 4'hF;
                        doe_q     <= 1'b0;
                        ad_oe_q   <= 1'b0;
                        a_oe_q    <= 1'b0;
                        bgack_n_q <= 1'b1;
                        state_q   <= TERM;
                    end
                end
                TERM: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign rdata_o   = rdata_q;
    assign br_n_o    = br_n_q;
    assign bgack_n_o = bgack_n_q;
    assign a_out_o   = a_out_q;
    assign ad_out_o  = ad_out_q;
    assign ad_oe_o   = ad_oe_q;
    assign a_oe_o    = a_oe_q;
    assign read_o    = read_q;
    assign fc_o      = fc_q;
    assign fcs_n_o   = fcs_n_q;
    assign ds_o      = ds_q;
    assign doe_o     = doe_q;

endmodule

// File: tb/tb_z3_bus_master.sv
// Bench for z3_bus_master: directed transactions, expected ACK responses
// queued by the stimulus and checked by an independent ACK monitor.
module tb_z3_bus_master;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [29:0] addr = 30'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  be = 4'hF;
    logic        bg_n = 1'b0;
    logic [31:0] ad_in = 32'h0;
    logic        dtack_n = 1'b0;
    logic        berr_n = 1'b1;

    logic        ack_o, err_o, br_n_o, bgack_n_o, ad_oe_o, a_oe_o, read_o;
    logic        fcs_n_o, doe_o;
    logic [31:0] rdata_o, ad_out_o;
    logic [5:0]  a_out_o;
    logic [2:0]  fc_o;
    logic [3:0]  ds_o;

    z3_bus_master #(.TIMEOUT(TO), .FC_VAL(3'b101)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .rw_i     (rw),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .be_i     (be),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .rdata_o  (rdata_o),
        .br_n_o   (br_n_o),
        .bg_n_i   (bg_n),
        .bgack_n_o(bgack_n_o),
        .a_out_o  (a_out_o),
        .ad_out_o (ad_out_o),
        .ad_in_i  (ad_in),
        .ad_oe_o  (ad_oe_o),
        .a_oe_o   (a_oe_o),
        .read_o   (read_o),
        .fc_o     (fc_o),
        .fcs_n_o  (fcs_n_o),
        .ds_o     (ds_o),
        .doe_o    (doe_o),
        .dtack_n_i(dtack_n),
        .berr_n_i (berr_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ACK pops one expected response
    always @(negedge clk) begin
        if (ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack with err=%b, expected no ack", err_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_err", 32'(err_o), 32'(mon_e.err));
                chk("ack_rdata", rdata_o, mon_e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic r, input logic [29:0] a, input logic [31:0] w,
                         input logic [3:0] b);
        req   = 1'b1;
        rw    = r;
        addr  = a;
        wdata = w;
        be    = b;
    endtask

    // Returns edges until ACK is seen, or -1 when the budget expires
    task automatic wait_ack(input int budget, output int n);
        int i;
        i = 0;
        n = -1;
        while (n < 0 && i < budget) begin
            tick();
            i++;
            if (ack_o === 1'b1) n = i;
        end
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_strobes", {28'h0, br_n_o, bgack_n_o, fcs_n_o, doe_o}, 32'h0000_000E);
        chk("rst_ds", 32'(ds_o), 32'h0000_000F);
        chk("rst_oe_ack", {26'h0, ad_oe_o, a_oe_o, read_o, ack_o, err_o, 1'b0}, 32'h0);
        chk("rst_fc", 32'(fc_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        rst = 1'b0;
        repeat (3) tick();

        // 1: minimum-latency read
        ad_in = 32'hDEAD_BEEF;
        start(1'b1, 30'h0200_0000, 32'h0, 4'hF);
        exp_q.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
        tick();
        chk("t1_e1_br", 32'(br_n_o), 32'h0);
        tick();
        chk("t1_e2_bgack", 32'(bgack_n_o), 32'h0);
        chk("t1_e2_oe", {29'h0, ad_oe_o, a_oe_o, read_o}, 32'h7);
        chk("t1_e2_ad", ad_out_o, 32'h0800_0000);
        chk("t1_e2_fc", 32'(fc_o), 32'h5);
        chk("t1_e2_fcs", 32'(fcs_n_o), 32'h1);
        tick();
        chk("t1_e3_fcs", 32'(fcs_n_o), 32'h0);
        chk("t1_e3_ad", ad_out_o, 32'h0800_0000);
        chk("t1_e3_ds", 32'(ds_o), 32'hF);
        tick();
        chk("t1_e4_ds", 32'(ds_o), 32'h0);
        chk("t1_e4_doe_adoe", {30'h0, doe_o, ad_oe_o}, 32'h2);
        wait_ack(4, lat);
        chk("t1_ack_edge", 32'(lat), 32'd1);
        chk("t1_err", 32'(err_o), 32'h0);
        tick();
        chk("t1_ack_pulse", 32'(ack_o), 32'h0);

        // 2: write with partial byte enables
        start(1'b0, 30'h0000_0041, 32'h1234_5678, 4'b0011);
        exp_q.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
        tick();
        tick();
        chk("t2_a_out", 32'(a_out_o), 32'h01);
        chk("t2_read", 32'(read_o), 32'h0);
        tick();
        tick();
        chk("t2_ds", 32'(ds_o), 32'h0000_000C);
        chk("t2_adoe", 32'(ad_oe_o), 32'h1);
        chk("t2_ad_wdata", ad_out_o, 32'h1234_5678);
        wait_ack(4, lat);
        chk("t2_ack_edge", 32'(lat), 32'd1);

        // 3: grant withheld
        bg_n = 1'b1;
        repeat (3) tick();
        ad_in = 32'hCAFE_0001;
        start(1'b1, 30'h0000_0100, 32'h0, 4'hF);
        exp_q.push_back('{err: 1'b0, rdata: 32'hCAFE_0001});
        repeat (10) tick();
        chk("t3_br_held", 32'(br_n_o), 32'h0);
        chk("t3_bgack_held", {30'h0, bgack_n_o, a_oe_o}, 32'h2);
        bg_n = 1'b0;
        tick();
        tick();
        chk("t3_bgack_e2", 32'(bgack_n_o), 32'h1);
        tick();
        chk("t3_bgack_e3", 32'(bgack_n_o), 32'h0);
        chk("t3_br_released", 32'(br_n_o), 32'h1);
        wait_ack(10, lat);
        chk("t3_ack_edge", 32'(lat), 32'd3);

        // 4: DTACK and BERR together; BERR wins, RDATA untouched
        dtack_n = 1'b1;
        repeat (3) tick();
        ad_in = 32'h1111_2222;
        start(1'b1, 30'h0000_0200, 32'h0, 4'hF);
        exp_q.push_back('{err: 1'b1, rdata: 32'hCAFE_0001});
        repeat (5) tick();
        chk("t4_in_data", {30'h0, doe_o, ack_o}, 32'h2);
        dtack_n = 1'b0;
        berr_n  = 1'b0;
        wait_ack(10, lat);
        chk("t4_ack_edge", 32'(lat), 32'd3);
        chk("t4_rdata_kept", rdata_o, 32'hCAFE_0001);
        dtack_n = 1'b1;
        berr_n  = 1'b1;
        repeat (3) tick();

        // 5: timeout with no DTACK
        ad_in = 32'h9999_9999;
        start(1'b1, 30'h0000_0300, 32'h0, 4'hF);
        exp_q.push_back('{err: 1'b1, rdata: 32'hCAFE_0001});
        repeat (4) tick();
        chk("t5_data_entry", 32'(doe_o), 32'h1);
        wait_ack(20, lat);
        chk("t5_timeout_edges", 32'(lat), 32'(TO));
        chk("t5_term_release", {28'h0, fcs_n_o, doe_o, ad_oe_o, a_oe_o}, 32'h8);
        chk("t5_term_ds_bgack", {27'h0, ds_o, bgack_n_o}, 32'h1F);

        // 6: reset in the middle of the data phase
        start(1'b1, 30'h0000_0400, 32'h0, 4'hF);
        repeat (6) tick();
        chk("t6_in_data", {30'h0, doe_o, ack_o}, 32'h2);
        rst = 1'b1;
        req = 1'b0;
        tick();
        chk("t6_rst_release", {27'h0, ds_o, fcs_n_o}, 32'h1F);
        chk("t6_rst_bus", {29'h0, bgack_n_o, br_n_o, ack_o}, 32'h6);
        tick();
        rst = 1'b0;
        dtack_n = 1'b0;
        repeat (3) tick();
        chk("t6_no_ack", 32'(ack_o), 32'h0);
        ad_in = 32'h55AA_55AA;
        start(1'b1, 30'h0000_0500, 32'h0, 4'hF);
        exp_q.push_back('{err: 1'b0, rdata: 32'h55AA_55AA});
        wait_ack(10, lat);
        chk("t6_recover_lat", 32'(lat), 32'd5);

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
